// File: rtl/fb_pkg.sv
// Shared constants, colour codes and address helpers for the pixel framebuffer.
package fb_pkg;

    localparam int unsigned PX_WIDTH  = 160;
    localparam int unsigned PX_HEIGHT = 120;
    localparam int unsigned DATA_W    = 3;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DEPTH     = PX_WIDTH * PX_HEIGHT;
    localparam int unsigned IDX_W     = $clog2(DEPTH);

    localparam logic [DATA_W-1:0] CLR_BLACK   = 3'b000;
    localparam logic [DATA_W-1:0] CLR_BLUE    = 3'b001;
    localparam logic [DATA_W-1:0] CLR_GREEN   = 3'b010;
    localparam logic [DATA_W-1:0] CLR_CYAN    = 3'b011;
    localparam logic [DATA_W-1:0] CLR_RED     = 3'b100;
    localparam logic [DATA_W-1:0] CLR_MAGENTA = 3'b101;
    localparam logic [DATA_W-1:0] CLR_YELLOW  = 3'b110;
    localparam logic [DATA_W-1:0] CLR_WHITE   = 3'b111;
    localparam logic [DATA_W-1:0] PL_COLOR    = CLR_WHITE;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    // Out-of-range addresses map to entry 0; callers must gate with in_range.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return in_range(addr) ? IDX_W'(addr) : '0;
    endfunction

endpackage

// File: rtl/fb_read_port.sv
// One synchronous read port: range check, optional write forward, registered output.
module fb_read_port
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] entry,
    input  logic              hit,
    input  logic [DATA_W-1:0] wr_data,
    output logic [IDX_W-1:0]  idx_c,
    output logic [DATA_W-1:0] data
);

    assign idx_c = idx_of(addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= CLR_BLACK;
        end else if (!in_range(addr)) begin
            data <= CLR_BLACK;
        end else if (hit) begin
            data <= wr_data;
        end else begin
            data <= entry;
        end
    end

endmodule

// File: rtl/pixel_framebuffer.sv
// Single-write dual-read pixel framebuffer with one-cycle frame clear.
// Optional FB_WRITE_FORWARD_EN: same-edge write data forwarded to matching reads.
module pixel_framebuffer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              memw,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic [ADDR_W-1:0] rmemaddr,
    input  logic [ADDR_W-1:0] rmemaddr2,
    input  logic [DATA_W-1:0] memi,
    output logic [DATA_W-1:0] memo,
    output logic [DATA_W-1:0] memo2
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic              wr_ok_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [IDX_W-1:0]  ra_idx_c;
    logic [IDX_W-1:0]  rb_idx_c;
    logic [DATA_W-1:0] entry_a_c;
    logic [DATA_W-1:0] entry_b_c;
    logic              hit_a_c;
    logic              hit_b_c;

    assign wr_ok_c  = ~rst & memw & in_range(memaddr);
    assign wr_idx_c = idx_of(memaddr);

    // Data array carries no reset; the valid bits provide the single-cycle clear.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_idx_c] <= memi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (wr_ok_c) begin
            vld[wr_idx_c] <= 1'b1;
        end
    end

    assign entry_a_c = vld[ra_idx_c] ? mem[ra_idx_c] : CLR_BLACK;
    assign entry_b_c = vld[rb_idx_c] ? mem[rb_idx_c] : CLR_BLACK;

`ifdef FB_WRITE_FORWARD_EN
    assign hit_a_c = wr_ok_c && (memaddr == rmemaddr);
    assign hit_b_c = wr_ok_c && (memaddr == rmemaddr2);
`else
    assign hit_a_c = 1'b0;
    assign hit_b_c = 1'b0;
`endif

    fb_read_port u_port_a (
        .clk     (clk),
        .rst     (rst),
        .addr    (rmemaddr),
        .entry   (entry_a_c),
        .hit     (hit_a_c),
        .wr_data (memi),
        .idx_c   (ra_idx_c),
        .data    (memo)
    );

    fb_read_port u_port_b (
        .clk     (clk),
        .rst     (rst),
        .addr    (rmemaddr2),
        .entry   (entry_b_c),
        .hit     (hit_b_c),
        .wr_data (memi),
        .idx_c   (rb_idx_c),
        .data    (memo2)
    );

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Self-checking bench for pixel_framebuffer: directed table, corner sequences, random vs model.
module tb_pixel_framebuffer;

    localparam int unsigned DEPTH = 160 * 120;
`ifdef FB_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        memw;
    logic [15:0] memaddr;
    logic [15:0] rmemaddr;
    logic [15:0] rmemaddr2;
    logic [2:0]  memi;
    logic [2:0]  memo;
    logic [2:0]  memo2;

    pixel_framebuffer dut (
        .clk       (clk),
        .rst       (rst),
        .memw      (memw),
        .memaddr   (memaddr),
        .rmemaddr  (rmemaddr),
        .rmemaddr2 (rmemaddr2),
        .memi      (memi),
        .memo      (memo),
        .memo2     (memo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] wa;
        logic [2:0]  wd;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  ea;
        logic [2:0]  eb;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    logic [2:0] model [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic r, logic w, int wa, int wd, int ra, int rb, int ea, int eb);
        vec_t v;
        v.r  = r;
        v.w  = w;
        v.wa = 16'(wa);
        v.wd = 3'(wd);
        v.ra = 16'(ra);
        v.rb = 16'(rb);
        v.ea = 3'(ea);
        v.eb = 3'(eb);
        return v;
    endfunction

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what a port should show after the edge, from the frame contents before it.
    function automatic logic [2:0] expect_rd(logic r, logic w, logic [15:0] wa,
                                             logic [2:0] wd, logic [15:0] a);
        if (r) return 3'd0;
        if (int'(a) >= int'(DEPTH)) return 3'd0;
        if (FWD && w && (wa == a)) return wd;
        return model[a];
    endfunction

    // Apply one cycle of inputs, advance one edge, compare both ports with the model.
    task automatic cyc(input logic r, input logic w, input logic [15:0] wa, input logic [2:0] wd,
                       input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [2:0] ea;
        logic [2:0] eb;
        ea = expect_rd(r, w, wa, wd, a);
        eb = expect_rd(r, w, wa, wd, b);
        rst = r; memw = w; memaddr = wa; memi = wd; rmemaddr = a; rmemaddr2 = b;
        if (r) begin
            for (int i = 0; i < int'(DEPTH); i++) model[i] = 3'd0;
        end else if (w && int'(wa) < int'(DEPTH)) begin
            model[wa] = wd;
        end
        @(posedge clk);
        #1;
        check({tag, " model memo"}, memo, ea);
        check({tag, " model memo2"}, memo2, eb);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 16'd19199;
            1:       return 16'(19200 + $urandom_range(0, 40));
            2:       return 16'($urandom_range(0, 65535));
            default: return 16'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 3'd0;
        rst = 1'b1; memw = 1'b0; memaddr = '0; memi = '0; rmemaddr = '0; rmemaddr2 = '0;
        @(posedge clk);
        #1;

        tbl[0]  = mk(1, 0, 0,     0, 0,     0,     0, 0);
        tbl[1]  = mk(0, 0, 0,     0, 0,     100,   0, 0);
        tbl[2]  = mk(0, 0, 0,     0, 19199, 19199, 0, 0);
        tbl[3]  = mk(0, 1, 161,   5, 160,   160,   0, 0);
        tbl[4]  = mk(0, 0, 0,     0, 161,   161,   5, 5);
        tbl[5]  = mk(0, 0, 0,     0, 160,   161,   0, 5);
        tbl[6]  = mk(0, 1, 19200, 7, 0,     19199, 0, 0);
        tbl[7]  = mk(0, 1, 65535, 7, 19200, 65535, 0, 0);
        tbl[8]  = mk(0, 0, 0,     0, 0,     19199, 0, 0);
        tbl[9]  = mk(0, 1, 50,    2, 0,     0,     0, 0);
        tbl[10] = mk(0, 1, 50,    6, 50,    50,    FWD ? 6 : 2, FWD ? 6 : 2);
        tbl[11] = mk(0, 0, 0,     0, 50,    0,     6, 0);
        tbl[12] = mk(0, 1, 10,    1, 0,     0,     0, 0);
        tbl[13] = mk(0, 1, 20,    4, 0,     0,     0, 0);
        tbl[14] = mk(0, 1, 30,    3, 10,    20,    1, 4);
        tbl[15] = mk(0, 1, 30,    5, 10,    20,    1, 4);
        tbl[16] = mk(0, 1, 30,    6, 10,    20,    1, 4);
        tbl[17] = mk(0, 0, 0,     0, 30,    30,    6, 6);

        for (int k = 0; k < NVEC; k++) begin
            cyc(tbl[k].r, tbl[k].w, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].rb, $sformatf("vec%0d", k));
            check($sformatf("vec%0d memo", k), memo, tbl[k].ea);
            check($sformatf("vec%0d memo2", k), memo2, tbl[k].eb);
        end

        // Mid-frame clear racing a write: the write must be lost.
        for (int i = 0; i < 10; i++) cyc(0, 1, 16'(i), 3'b011, 16'd0, 16'd0, "fill");
        cyc(0, 0, 0, 0, 16'd5, 16'd9, "fill rd");
        check("fill rd memo", memo, 3'b011);
        check("fill rd memo2", memo2, 3'b011);
        cyc(1, 1, 16'd5, 3'b111, 16'd5, 16'd9, "clr");
        check("clr cycle memo", memo, 3'b000);
        check("clr cycle memo2", memo2, 3'b000);
        for (int i = 0; i < 10; i += 2) begin
            cyc(0, 0, 0, 0, 16'(i), 16'(i + 1), "post clr");
            check($sformatf("post clr memo %0d", i), memo, 3'b000);
            check($sformatf("post clr memo2 %0d", i + 1), memo2, 3'b000);
        end
        cyc(0, 1, 16'd7, 3'b100, 16'd0, 16'd0, "post clr wr");
        cyc(0, 0, 0, 0, 16'd7, 16'd7, "post clr rd");
        check("post clr wr memo", memo, 3'b100);

        // Randomised traffic, heavy on a small window so collisions happen.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), rand_addr(),
                3'($urandom_range(0, 7)), rand_addr(), rand_addr(), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
